// File: rtl/uns_6x3_div.sv
`default_nettype none
// ============================================================================
// Module      : uns_6x3_div
// Description : Unsigned 6-bit / 3-bit divider by repeated subtraction with a
//               START/DONE handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uns_6x3_div #(
  parameter int DIVIDEND_WIDTH = 6,
  parameter int DIVISOR_WIDTH  = 3
) (
  input  logic                      SYS_CLOCK,
  input  logic                      SYS_RESET,
  input  logic                      START,
  input  logic [DIVIDEND_WIDTH-1:0] DIVIDEND,
  input  logic [DIVISOR_WIDTH-1:0]  DIVISOR,
  output logic [DIVIDEND_WIDTH-1:0] QUOTIENT,
  output logic [DIVISOR_WIDTH-1:0]  REMAINDER,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      DIV_ZERO
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SUB   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [DIVIDEND_WIDTH-1:0] c_q_one  = DIVIDEND_WIDTH'(1);
  localparam logic [DIVIDEND_WIDTH-1:0] c_q_ones = '1;

  state_t                    r_state;
  logic [DIVIDEND_WIDTH-1:0] r_n;
  logic [DIVISOR_WIDTH-1:0]  r_d;
  logic [DIVIDEND_WIDTH-1:0] r_q;

  logic [DIVIDEND_WIDTH-1:0] w_d_ext;
  logic                      w_n_ge_d;

  // Divisor is widened so compare and subtract happen at dividend width.
  assign w_d_ext  = {{(DIVIDEND_WIDTH-DIVISOR_WIDTH){1'b0}}, r_d};
  assign w_n_ge_d = (r_n >= w_d_ext);

  assign BUSY = (r_state != S_IDLE);
  assign DONE = (r_state == S_DONE);

  always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_d       <= '0;
      r_q       <= '0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      DIV_ZERO  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_n     <= DIVIDEND;
            r_d     <= DIVISOR;
            r_q     <= '0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_d == '0) begin
            QUOTIENT  <= c_q_ones;
            REMAINDER <= '0;
            DIV_ZERO  <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          if (w_n_ge_d) begin
            r_n <= r_n - w_d_ext;
            r_q <= r_q + c_q_one;
          end else begin
            // Running remainder is below the divisor here, so truncation is exact.
            QUOTIENT  <= r_q;
            REMAINDER <= r_n[DIVISOR_WIDTH-1:0];
            DIV_ZERO  <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uns_6x3_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_uns_6x3_div
// Description : Directed self-checking bench for uns_6x3_div.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uns_6x3_div;

  logic       SYS_CLOCK;
  logic       SYS_RESET;
  logic       START;
  logic [5:0] DIVIDEND;
  logic [2:0] DIVISOR;
  logic [5:0] QUOTIENT;
  logic [2:0] REMAINDER;
  logic       BUSY;
  logic       DONE;
  logic       DIV_ZERO;

  int n_checks = 0;
  int n_pass   = 0;

  uns_6x3_div #(
    .DIVIDEND_WIDTH(6),
    .DIVISOR_WIDTH (3)
  ) dut (
    .SYS_CLOCK(SYS_CLOCK),
    .SYS_RESET(SYS_RESET),
    .START    (START),
    .DIVIDEND (DIVIDEND),
    .DIVISOR  (DIVISOR),
    .QUOTIENT (QUOTIENT),
    .REMAINDER(REMAINDER),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .DIV_ZERO (DIV_ZERO)
  );

  initial SYS_CLOCK = 1'b0;
  always #5 SYS_CLOCK = ~SYS_CLOCK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".quotient"}, int'(QUOTIENT), 0);
    check({tag, ".remainder"}, int'(REMAINDER), 0);
    check({tag, ".div_zero"}, int'(DIV_ZERO), 0);
    check({tag, ".busy"}, int'(BUSY), 0);
    check({tag, ".done"}, int'(DONE), 0);
  endtask

  // Called at a falling edge; returns at the falling edge of the IDLE cycle after DONE.
  // poke1/poke2 name accept-relative edges at which a 7/7 START is re-asserted.
  task automatic run_op(input string name, input int a, input int b,
                        input int eq, input int er, input int edz, input int elat,
                        input int poke1, input int poke2);
    int edges;
    int busy_cyc;
    int seen;
    START    = 1'b1;
    DIVIDEND = 6'(a);
    DIVISOR  = 3'(b);
    @(posedge SYS_CLOCK);
    #1;
    START    = 1'b0;
    DIVIDEND = 6'($urandom);
    DIVISOR  = 3'($urandom);
    edges    = 0;
    busy_cyc = 0;
    seen     = 0;
    while (edges < 100) begin
      @(negedge SYS_CLOCK);
      if (BUSY) busy_cyc++;
      if (DONE) begin
        seen = 1;
        break;
      end
      if (edges + 1 == poke1 || edges + 1 == poke2) begin
        START    = 1'b1;
        DIVIDEND = 6'd7;
        DIVISOR  = 3'd7;
      end
      @(posedge SYS_CLOCK);
      edges++;
      #1;
      START    = 1'b0;
      DIVIDEND = 6'($urandom);
    end
    check({name, ".done_seen"}, seen, 1);
    check({name, ".latency"}, edges, elat);
    check({name, ".busy_cycles"}, busy_cyc, elat + 1);
    check({name, ".quotient"}, int'(QUOTIENT), eq);
    check({name, ".remainder"}, int'(REMAINDER), er);
    check({name, ".div_zero"}, int'(DIV_ZERO), edz);
    @(posedge SYS_CLOCK);
    @(negedge SYS_CLOCK);
    check({name, ".done_pulse_end"}, int'(DONE), 0);
    check({name, ".busy_end"}, int'(BUSY), 0);
    check({name, ".quotient_held"}, int'(QUOTIENT), eq);
    check({name, ".remainder_held"}, int'(REMAINDER), er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    SYS_RESET = 1'b1;
    START     = 1'b0;
    DIVIDEND  = '0;
    DIVISOR   = '0;
    repeat (2) @(negedge SYS_CLOCK);
    check_idle_zero("in_reset");
    SYS_RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge SYS_CLOCK);
      check_idle_zero("post_reset");
    end

    run_op("d42_5", 42, 5, 8, 2, 0, 10, 0, 0);
    run_op("d5_7", 5, 7, 0, 5, 0, 2, 0, 0);
    run_op("d63_1", 63, 1, 63, 0, 0, 65, 0, 0);
    run_op("d20_0", 20, 0, 63, 0, 1, 1, 0, 0);
    run_op("d20_3", 20, 3, 6, 2, 0, 8, 0, 0);
    run_op("d49_2", 49, 2, 24, 1, 0, 26, 3, 10);
    for (int i = 0; i < 4; i++) begin
      @(negedge SYS_CLOCK);
      check("no_second_op.busy", int'(BUSY), 0);
      check("no_second_op.quotient", int'(QUOTIENT), 24);
    end

    // Abort 60/1 with an asynchronous reset mid-cycle after edge 20.
    START    = 1'b1;
    DIVIDEND = 6'd60;
    DIVISOR  = 3'd1;
    @(posedge SYS_CLOCK);
    #1;
    START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge SYS_CLOCK);
      check("abort.busy_before", int'(BUSY), 1);
      check("abort.done_before", int'(DONE), 0);
      @(posedge SYS_CLOCK);
    end
    check("abort.quotient_before", int'(QUOTIENT), 24);
    #2;
    SYS_RESET = 1'b1;
    #1;
    check_idle_zero("abort_reset");
    @(negedge SYS_CLOCK);
    SYS_RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge SYS_CLOCK);
      check_idle_zero("after_abort");
    end

    run_op("d6_3", 6, 3, 2, 0, 0, 4, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uns_6x3_div.md
# uns_6x3_div

Unsigned 6-bit by 3-bit divider built from a repeated-subtraction datapath and a small controller FSM. It is the inverse operation of the team's 3x3 unsigned multiplier, which forms a product by repeated addition. The divider accepts a 6-bit dividend, which covers the full multiplier product range, and a 3-bit divisor. It returns a 6-bit quotient and a 3-bit remainder through a START/DONE handshake. It sits beside the multiplier in the arithmetic unit, and the verification bench uses it to check that A*B / B recovers A.

## Interface
Parameters:
- DIVIDEND_WIDTH, 6, dividend and quotient width
- DIVISOR_WIDTH, 3, divisor and remainder width

Ports:
- SYS_CLOCK  in  1  system clock; all state changes on rising edge
- SYS_RESET  in  1  reset, asynchronous, active-high
- START  in  1  request; sampled only in IDLE
- DIVIDEND  in  DIVIDEND_WIDTH  unsigned dividend; captured on accept edge
- DIVISOR  in  DIVISOR_WIDTH  unsigned divisor; captured on accept edge
- QUOTIENT  out  DIVIDEND_WIDTH  registered quotient; held until next completion
- REMAINDER  out  DIVISOR_WIDTH  registered remainder; held until next completion
- BUSY  out  1  high from accept edge until the return to IDLE
- DONE  out  1  one-cycle completion pulse
- DIV_ZERO  out  1  registered; set at completion if the divisor was 0

Clocking and reset (already decided): one clock; reset is asynchronous and active-high. The ports are SYS_CLOCK and SYS_RESET.

## Operation
- Internal registers:
  - N_REG (DIVIDEND_WIDTH): running remainder.
  - D_REG (DIVISOR_WIDTH, zero-extended for compare/subtract).
  - Q_REG (DIVIDEND_WIDTH): quotient counter.
- FSM states: IDLE, CHECK, SUB, DONE.
- IDLE:
  - If START=1, load N_REG<=DIVIDEND, D_REG<=DIVISOR and Q_REG<=0, then go to CHECK.
  - Otherwise stay in IDLE.
- CHECK:
  - If D_REG==0, go to DONE and load QUOTIENT<=all ones (63), REMAINDER<=0, DIV_ZERO<=1.
  - Otherwise go to SUB.
- SUB:
  - If N_REG>=D_REG, set N_REG<=N_REG-D_REG and Q_REG<=Q_REG+1, and stay in SUB.
  - Otherwise go to DONE and load QUOTIENT<=Q_REG, REMAINDER<=N_REG[DIVISOR_WIDTH-1:0], DIV_ZERO<=0.
- DONE: DONE=1 for exactly this one cycle, then unconditionally go to IDLE.
- Arithmetic rules:
  - The compare is unsigned at DIVIDEND_WIDTH bits.
  - The subtract never underflows.
  - Q_REG cannot overflow, because at most 63 subtractions occur when the divisor is at least 1.
  - On exit, the remainder is always less than the divisor, so truncating it to DIVISOR_WIDTH bits is lossless.
- START while not in IDLE (including the DONE cycle) is ignored. It is not queued.
- DIVIDEND and DIVISOR may change freely after the accept edge. Only the captured values are used.
- Reset outputs and state:
  - All of QUOTIENT, REMAINDER, DIV_ZERO, DONE and BUSY are 0.
  - Internal registers are 0 and the state is IDLE.
  - Reset mid-operation aborts the operation: no DONE is produced and the outputs return to 0.

## Timing
- Edge 0 is the accept edge: START=1 sampled in IDLE.
- BUSY rises after edge 0. It is a decode of state≠IDLE, so it stays high through the DONE cycle and falls after the DONE→IDLE edge.
- For a non-zero divisor with quotient q:
  - CHECK runs at edge 1.
  - Subtractions occur at edges 2..q+1.
  - The failing compare at edge q+2 enters DONE and updates the outputs.
  - DONE is high during the cycle after edge q+2, so latency is q+2 edges.
  - The best case is q=0, with DONE after edge 2.
  - The worst case is 63/1, with DONE after edge 65.
- For divisor 0, DONE rises after edge 1.
- QUOTIENT, REMAINDER and DIV_ZERO change only on the edge that enters DONE. They are valid in the DONE cycle and stable afterwards.
- Back-to-back operation: a START sampled in the IDLE cycle immediately after DONE is accepted. The minimum issue interval is therefore q+4 cycles.
- DONE is a pure state decode. It has no combinational path from the inputs.

## Test plan
- Reset, then hold SYS_RESET=0 and START=0 for 5 cycles. Required: all outputs remain 0, BUSY=0, DONE never rises.
- Apply DIVIDEND=42, DIVISOR=5 with START for one cycle. Required: DONE after edge 10, QUOTIENT=8, REMAINDER=2, DIV_ZERO=0. BUSY is high for 11 cycles.
- Apply 5/7, then immediately 63/1 back-to-back (second START in the IDLE cycle after DONE). Required: Q=0, R=5 after edge 2. Then Q=63, R=0 after edge 65 of the second operation.
- Apply 20/0. Required: DONE after edge 1, QUOTIENT=63, REMAINDER=0, DIV_ZERO=1. A following 20/3 gives Q=6, R=2 and clears DIV_ZERO.
- Start 49/2, pulse START again at edges 3 and 10 with 7/7, and change DIVIDEND mid-operation. Required: only 49/2 is computed (Q=24, R=1, DONE after edge 26), and no second operation occurs.
- Start 60/1 and assert SYS_RESET asynchronously mid-cycle at edge 20. Required: outputs drop to 0 immediately, there is no DONE, and the state is IDLE. A fresh 6/3 afterwards gives Q=2, R=0.
